// File: rtl/cnt_snapshot_fifo_pkg.sv
// Shared constants and record types for the counter snapshot path.
// Holds the default widths, the buffer depth and the snapshot record layout.
package cnt_snapshot_fifo_pkg;

    localparam int CNT_W      = 64;
    localparam int EPOCH_W    = 16;
    localparam int SNAP_DEPTH = 4;

    // Snapshot record at the default widths; epoch sits above the count.
    typedef struct packed {
        logic [EPOCH_W-1:0] epoch;
        logic [CNT_W-1:0]   count;
    } snapshot_t;

    // Width of an occupancy count that can hold the value `depth`.
    function automatic int level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/cnt_snapshot_fifo_sync_fifo.sv
// Single-clock FIFO with registered storage and an occupancy count.
// A push while full is accepted only when a pop happens in the same cycle.
module sync_fifo
    import cnt_snapshot_fifo_pkg::*;
#(
    parameter int WIDTH = EPOCH_W + CNT_W,
    parameter int DEPTH = SNAP_DEPTH
) (
    input  logic                      clk,
    input  logic                      nrst,
    input  logic                      push_i,
    input  logic                      pop_i,
    input  logic [WIDTH-1:0]          wdata_i,
    output logic [WIDTH-1:0]          rdata_o,
    output logic                      full_o,
    output logic                      empty_o,
    output logic [level_w(DEPTH)-1:0] level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic             do_push, do_pop;

    assign full_o  = (level_q == (AW+1)'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    // Pointers wrap on their own because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // NOTE: storage has no reset; an entry is only read after a push wrote it.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/cnt_snapshot_fifo.sv
// Captures {epoch, counter} timestamps on trig into a small FIFO.
// The epoch counts counter wraps so the snapshot extends the counter width.
module cnt_snapshot_fifo
    import cnt_snapshot_fifo_pkg::*;
#(
    parameter int N     = CNT_W,
    parameter int E     = EPOCH_W,
    parameter int DEPTH = SNAP_DEPTH
) (
    input  logic                      clk,
    input  logic                      nrst,
    input  logic [N-1:0]              counter,
    input  logic                      cout,
    input  logic                      trig,
    output logic [E+N-1:0]            snap_data,
    output logic                      snap_valid,
    input  logic                      snap_ready,
    output logic [level_w(DEPTH)-1:0] level,
    output logic                      drop
);

    typedef struct packed {
        logic [E-1:0] epoch;
        logic [N-1:0] count;
    } snap_t;

    logic [E-1:0] epoch_q, epoch_d;
    logic         drop_q, drop_d;
    snap_t        capture;
    logic         full, empty, pop;

    assign snap_valid = ~empty;
    assign pop        = snap_valid & snap_ready;
    assign drop       = drop_q;

    // On the wrap cycle the counter already reads 0, so the epoch seen by
    // the capture must include this cycle's carry to stay monotonic.
    always_comb begin
        epoch_d       = epoch_q + E'(cout);
        capture.epoch = epoch_d;
        capture.count = counter;
        drop_d        = drop_q | (trig & full & ~pop);
    end

    // NOTE: sequential state is assigned with <= so all registers update together.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            epoch_q <= '0;
            drop_q  <= 1'b0;
        end else begin
            epoch_q <= epoch_d;
            drop_q  <= drop_d;
        end
    end

    sync_fifo #(
        .WIDTH (E + N),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .nrst    (nrst),
        .push_i  (trig),
        .pop_i   (pop),
        .wdata_i (capture),
        .rdata_o (snap_data),
        .full_o  (full),
        .empty_o (empty),
        .level_o (level)
    );

endmodule

// File: tb/tb_cnt_snapshot_fifo.sv
// Self-checking bench for cnt_snapshot_fifo driven by a small upstream counter.
// Expected values come from a queue-based model of the snapshot rules.
module tb_cnt_snapshot_fifo;

    localparam int N     = 8;
    localparam int E     = 4;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          nrst = 1'b0;
    logic          cin = 1'b0;
    logic [N-1:0]  cnt;
    logic          cout;
    logic          trig = 1'b0;
    logic          snap_ready = 1'b0;
    logic [E+N-1:0] snap_data;
    logic          snap_valid;
    logic [LW-1:0] level;
    logic          drop;

    int checks_total  = 0;
    int checks_passed = 0;

    logic [E+N-1:0] model_q[$];
    int             epoch_m = 0;
    logic           drop_m  = 1'b0;

    always #5 clk = ~clk;

    // Upstream counter: registered count with a carry pulse on the wrap cycle.
    always @(posedge clk) begin
        if (!nrst) begin
            cnt  <= '0;
            cout <= 1'b0;
        end else begin
            {cout, cnt} <= {1'b0, cnt} + (N+1)'(cin);
        end
    end

    cnt_snapshot_fifo #(.N(N), .E(E), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .counter    (cnt),
        .cout       (cout),
        .trig       (trig),
        .snap_data  (snap_data),
        .snap_valid (snap_valid),
        .snap_ready (snap_ready),
        .level      (level),
        .drop       (drop)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        assert (obs === exp) checks_passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One clock: apply inputs, advance the model, then compare after the edge.
    task automatic step(input logic t, input logic r);
        logic do_pop;
        trig       = t;
        snap_ready = r;
        if (!nrst) begin
            model_q.delete();
            epoch_m = 0;
            drop_m  = 1'b0;
        end else begin
            do_pop = (model_q.size() != 0) && r;
            if (do_pop) void'(model_q.pop_front());
            if (t) begin
                if (model_q.size() < DEPTH)
                    model_q.push_back({4'((epoch_m + int'(cout)) % 16), cnt});
                else
                    drop_m = 1'b1;
            end
            if (cout) epoch_m = (epoch_m + 1) % 16;
        end
        @(posedge clk);
        #1;
        check("snap_valid", 32'(snap_valid), 32'(model_q.size() != 0));
        check("level", 32'(level), 32'(model_q.size()));
        check("drop", 32'(drop), 32'(drop_m));
        if (model_q.size() != 0) check("snap_data", 32'(snap_data), 32'(model_q[0]));
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        step(1'b1, 1'b0);
        nrst = 1'b1;
    endtask

    task automatic run_until(input logic [N-1:0] val, input logic need_cout);
        int n = 0;
        while (!(cnt == val && (!need_cout || cout)) && n < 600) begin
            step(1'b0, 1'b0);
            n++;
        end
        check("wait_budget", 32'(n < 600), 32'd1);
    endtask

    initial begin
        cin = 1'b1;
        do_reset();
        check("reset_valid", 32'(snap_valid), 32'd0);
        check("reset_level", 32'(level), 32'd0);

        // Basic capture and pop.
        run_until(8'h05, 1'b0);
        step(1'b1, 1'b0);
        check("basic_data", 32'(snap_data), 32'h005);
        step(1'b0, 1'b1);
        check("basic_popped", 32'(snap_valid), 32'd0);

        // Wrap-cycle consistency and the cycle after.
        run_until(8'h00, 1'b1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        check("wrap_data", 32'(snap_data), 32'h100);
        step(1'b0, 1'b1);
        check("wrap_next_data", 32'(snap_data), 32'h101);
        step(1'b0, 1'b1);

        // Overflow sets drop; first four entries pop in order.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        check("full_level", 32'(level), 32'd4);
        check("full_drop", 32'(drop), 32'd1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1);

        // Full with concurrent pop accepts the push.
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        check("fullpop_level", 32'(level), 32'd4);
        check("fullpop_drop", 32'(drop), 32'd0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1);

        // Sixteen wraps bring the epoch back to zero.
        do_reset();
        for (int w = 0; w < 16; w++) begin
            run_until(8'h00, 1'b1);
            step(1'b0, 1'b0);
        end
        step(1'b1, 1'b0);
        check("epoch_wrap_data", 32'(snap_data), 32'h001);
        step(1'b0, 1'b1);

        // Mid-operation reset discards entries and clears epoch.
        run_until(8'h00, 1'b1);
        step(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        check("pre_reset_level", 32'(level), 32'd3);
        do_reset();
        check("mid_reset_valid", 32'(snap_valid), 32'd0);
        check("mid_reset_level", 32'(level), 32'd0);
        check("mid_reset_drop", 32'(drop), 32'd0);
        step(1'b1, 1'b0);
        check("mid_reset_epoch", 32'(snap_data[E+N-1:N]), 32'd0);

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            cin = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0));
            end
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
